// File: rtl/matrix_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_bank_if
//  Description : Bundles the loader stream port and the cell-engine read port
//                of one matrix_bank.
//                master : host loader / cell engine side (drives requests)
//                slave  : matrix_bank side (drives status and read data)
//  Signals     : load_start, cols_m1, rows_m1, wr_valid, wr_data -> bank
//                wr_ready, busy, loaded, dim_cols_m1, dim_rows_m1 <- bank
//                rx, ry, read -> bank ; out, rd_err <- bank
//  Revision    : 1.0  initial release
// ============================================================================
interface matrix_bank_if #(
    parameter int maxWidthLen = 2,
    parameter int sizeValue   = 16
);
    logic                   load_start;
    logic [maxWidthLen-1:0] cols_m1;
    logic [maxWidthLen-1:0] rows_m1;
    logic                   wr_valid;
    logic [sizeValue-1:0]   wr_data;
    logic                   wr_ready;
    logic                   busy;
    logic                   loaded;
    logic [maxWidthLen-1:0] dim_cols_m1;
    logic [maxWidthLen-1:0] dim_rows_m1;
    logic [maxWidthLen-1:0] rx;
    logic [maxWidthLen-1:0] ry;
    logic                   read;
    logic [sizeValue-1:0]   out;
    logic                   rd_err;

    modport master (
        output load_start, cols_m1, rows_m1, wr_valid, wr_data, rx, ry, read,
        input  wr_ready, busy, loaded, dim_cols_m1, dim_rows_m1, out, rd_err
    );

    modport slave (
        input  load_start, cols_m1, rows_m1, wr_valid, wr_data, rx, ry, read,
        output wr_ready, busy, loaded, dim_cols_m1, dim_rows_m1, out, rd_err
    );
endinterface
`default_nettype wire

// File: rtl/matrix_bank.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_bank
//  Description : Single-matrix storage bank. A load FSM accepts row-major
//                values over a valid/ready stream, auto-increments the
//                column/row write counters and latches the dimensions. A
//                registered read port returns mem[{ry,rx}] one cycle after
//                each read strobe, in every state.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - matrix_bank_if.slave (load stream, status, read port)
//  Options     : MATRIX_BANK_BOUNDS_EN - when defined, reads outside the
//                latched dimensions return 0 with rd_err = 1; otherwise
//                rd_err is tied low and raw memory words are returned.
//  Revision    : 1.0  initial release
// ============================================================================
module matrix_bank #(
    parameter int maxWidthLen = 2,
    parameter int sizeValue   = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    matrix_bank_if.slave   bus
);
    localparam int                     c_DEPTH = 1 << (2 * maxWidthLen);
    localparam logic [maxWidthLen-1:0] c_ONE   = {{(maxWidthLen-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [maxWidthLen-1:0] r_wx;
    logic [maxWidthLen-1:0] r_wy;
    logic [maxWidthLen-1:0] w_wx_nxt;
    logic [maxWidthLen-1:0] w_wy_nxt;
    logic [maxWidthLen-1:0] r_dim_cols;
    logic [maxWidthLen-1:0] r_dim_rows;
    logic [maxWidthLen-1:0] w_dim_cols_nxt;
    logic [maxWidthLen-1:0] w_dim_rows_nxt;
    logic                   r_loaded;
    logic                   w_loaded_nxt;
    logic                   w_accept;

    // Storage is deliberately not reset so contents survive rst and reloads.
    logic [sizeValue-1:0]   r_mem [c_DEPTH];
    logic [sizeValue-1:0]   r_out;

    assign w_accept = (r_state == ST_LOAD) && bus.wr_valid;

    // ------------------------------------------------------------------
    // Load FSM: next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_wx_nxt       = r_wx;
        w_wy_nxt       = r_wy;
        w_dim_cols_nxt = r_dim_cols;
        w_dim_rows_nxt = r_dim_rows;
        w_loaded_nxt   = r_loaded;
        case (r_state)
            ST_IDLE: begin
                if (bus.load_start) begin
                    w_dim_cols_nxt = bus.cols_m1;
                    w_dim_rows_nxt = bus.rows_m1;
                    w_wx_nxt       = '0;
                    w_wy_nxt       = '0;
                    w_loaded_nxt   = 1'b0;
                    w_state_nxt    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    if (r_wx == r_dim_cols) begin
                        // End of a row; the last row's wrap is harmless
                        // because the FSM leaves LOAD on that beat.
                        w_wx_nxt = '0;
                        w_wy_nxt = r_wy + c_ONE;
                        if (r_wy == r_dim_rows) begin
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_wx_nxt = r_wx + c_ONE;
                    end
                end
            end
            ST_DONE: begin
                w_loaded_nxt = 1'b1;
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wx       <= '0;
            r_wy       <= '0;
            r_dim_cols <= '0;
            r_dim_rows <= '0;
            r_loaded   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wx       <= w_wx_nxt;
            r_wy       <= w_wy_nxt;
            r_dim_cols <= w_dim_cols_nxt;
            r_dim_rows <= w_dim_rows_nxt;
            r_loaded   <= w_loaded_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Storage write port (row-major {wy, wx})
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[{r_wy, r_wx}] <= bus.wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Registered read port. Non-blocking update means a same-address
    // write in the same cycle is not yet visible: the old word is read.
    // ------------------------------------------------------------------
`ifdef MATRIX_BANK_BOUNDS_EN
    logic r_rd_err;
    logic w_oob;

    assign w_oob = (bus.rx > r_dim_cols) || (bus.ry > r_dim_rows);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out    <= '0;
            r_rd_err <= 1'b0;
        end else if (bus.read) begin
            if (w_oob) begin
                r_out    <= '0;
                r_rd_err <= 1'b1;
            end else begin
                r_out    <= r_mem[{bus.ry, bus.rx}];
                r_rd_err <= 1'b0;
            end
        end
    end

    assign bus.rd_err = r_rd_err;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
        end else if (bus.read) begin
            r_out <= r_mem[{bus.ry, bus.rx}];
        end
    end

    assign bus.rd_err = 1'b0;
`endif

    assign bus.out         = r_out;
    assign bus.wr_ready    = (r_state == ST_LOAD);
    assign bus.busy        = (r_state == ST_LOAD);
    assign bus.loaded      = r_loaded;
    assign bus.dim_cols_m1 = r_dim_cols;
    assign bus.dim_rows_m1 = r_dim_rows;

endmodule
`default_nettype wire
